mem_resp_4c: RTL
================

# mem_resp_4c

Multi-cycle main-memory responder that serves the CPU's instruction-fetch and data-access request ports. It replaces the single-cycle instruction and data memories for the cache/multi-cycle phase. It accepts at most one request per cycle from two requesters (I-side, D-side) over a valid/ready handshake. Each accepted read returns its data a fixed LATENCY cycles later, tagged with the originating port.

## Interface
- DWIDTH, 16, data word width
- AWIDTH, 16, byte-address width
- DEPTH_LOG2, 15, log2 of array size in words
- LATENCY, 4, read latency in cycles (≥1)
- STARVE, 4, consecutive I-side denials before I-side is forced to win

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset: synchronous, active-high
- i_req_valid  in  1  I-side read request
- i_req_addr  in  AWIDTH  I-side byte address
- i_req_ready  out  1  I-side request accepted this cycle
- d_req_valid  in  1  D-side request
- d_req_wr  in  1  1=write, 0=read
- d_req_addr  in  AWIDTH  D-side byte address
- d_req_wdata  in  DWIDTH  write data
- d_req_ready  out  1  D-side request accepted this cycle
- rsp_valid  out  1  read data valid (one-cycle pulse per read)
- rsp_port  out  1  0=I-side, 1=D-side
- rsp_data  out  DWIDTH  read data
- busy  out  1  any read in flight

## Operation
- Word index = addr[DEPTH_LOG2:1]; addr[0] is ignored. Upper address bits are ignored, so addresses wrap modulo 2^DEPTH_LOG2 words.
- Handshake: a request is accepted in a cycle where valid && ready. Ready is combinational from both valids plus arbiter state. The requester holds valid/addr/wr/wdata stable until it sees ready. A request is never accepted while ready is low.
- Arbitration (one grant per cycle):
  - Only one valid: that side wins.
  - Both valid: D wins (older pipeline stage), unless starve_cnt == STARVE, in which case I wins.
- starve_cnt:
  - Increments (saturating at STARVE) on each cycle I is valid but not granted.
  - Clears when I is granted or I is not valid.
- Write accepted: the array is updated at the end of that cycle. No response is produced and busy is unaffected.
- Read accepted: the array word is sampled in the acceptance cycle, so a later write does not alter an in-flight read. {1, port, data} enters stage 0 of the response pipeline.
- Response pipeline is a LATENCY-deep shift register of {valid, port, data}. The last stage drives rsp_*.
- rsp_data/rsp_port hold their last value when rsp_valid=0. Consumers qualify on rsp_valid only.
- busy = OR of all pipeline-stage valid bits.
- Array contents are not cleared by rst. The bench preloads them.

## Timing
- Reset values: rsp_valid=0, rsp_port=0, rsp_data=0, busy=0, starve_cnt=0, all pipeline valid bits 0.
- i_req_ready and d_req_ready are combinational. While rst=1, both are forced to 0.
- Read accepted in cycle N → rsp_valid=1 in cycle N+LATENCY for exactly one cycle.
- Throughput: one read per cycle; back-to-back reads give back-to-back responses in acceptance order.
- Write in cycle N, read of the same word accepted in cycle N+1 or later → returns the new data. A same-cycle write and read is impossible (single grant).
- Reset mid-operation: rst high at an edge discards every in-flight read. No rsp_valid appears from reads accepted before reset. A write accepted in the cycle before reset still commits.
- starve_cnt update and grant decision use the current-cycle values.

## Structure
- Shared package mem_pkg holds:
  - RSP_PORT_I=1'b0 and RSP_PORT_D=1'b1
  - default DWIDTH/AWIDTH constants
  - a packed struct for a response-pipeline stage {valid, port, data}
- Sub-module resp_pipe: parameterised LATENCY-deep shift register with synchronous clear. It is instantiated once.
- The arbiter, starvation counter and array stay in the top level.

## Test plan
- Preload word 0x0010=0xABCD. I read of 0x0010, accepted cycle 5 → i_req_ready=1 in cycle 5; rsp_valid=1, rsp_port=0, rsp_data=0xABCD in cycle 9; busy high cycles 6–9.
- D write 0x0020←0x1234 in cycle 3, D read 0x0021 in cycle 4 → rsp_port=1, rsp_data=0x1234 in cycle 8; the write produces no response.
- I and D reads both valid in cycle 2 → d_req_ready=1, i_req_ready=0 in cycle 2; I accepted in cycle 3; responses D in cycle 6, I in cycle 7.
- D valid every cycle from cycle 0 and I held valid from cycle 0 → I denied cycles 0–3, granted in cycle 4 with d_req_ready=0; D resumes winning in cycle 5.
- Reads accepted in cycles 0, 1, 2; rst=1 in cycle 3 → rsp_valid stays 0 for cycles 3–8, busy=0 from cycle 4; a preloaded word re-read after reset returns its original value.
- DEPTH_LOG2=8: write 0x0004←0x5A5A, read 0x0204 → returns 0x5A5A (wrap-around).

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and the response-pipeline stage record for the multi-cycle memory responder.
package mem_pkg;

   localparam logic RSP_PORT_I = 1'b0;
   localparam logic RSP_PORT_D = 1'b1;

   localparam int MEM_DWIDTH = 16;
   localparam int MEM_AWIDTH = 16;

   typedef struct packed {
      logic                  valid;
      logic                  port;
      logic [MEM_DWIDTH-1:0] data;
   } rsp_stage_t;

endpackage

// File: rtl/mem_resp_4c_resp_pipe.sv
// LATENCY-deep response shift register; empty slots keep their last port/data so the output holds.
module resp_pipe
   import mem_pkg::*;
#(
   parameter type stage_t = rsp_stage_t,
   parameter int  LATENCY = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  stage_t stage_in,
   output stage_t stage_out,
   output logic   any_valid
);

   stage_t stage_q [LATENCY];
   stage_t stage_d [LATENCY];
   stage_t src     [LATENCY];

   genvar gi;
   generate
      for (gi = 0; gi < LATENCY; gi++) begin : g_src
         if (gi == 0) begin : g_head
            assign src[gi] = stage_in;
         end else begin : g_link
            assign src[gi] = stage_q[gi-1];
         end
      end
   endgenerate

   // A bubble only drops the valid bit; payload is retained so rsp_port/rsp_data hold.
   always_comb begin
      for (int i = 0; i < LATENCY; i++) begin
         stage_d[i]       = stage_q[i];
         stage_d[i].valid = 1'b0;
         if (src[i].valid) begin
            stage_d[i] = src[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < LATENCY; i++) begin
         if (rst) begin
            stage_q[i] <= '0;
         end else begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         any_valid = any_valid | stage_q[i].valid;
      end
   end

   assign stage_out = stage_q[LATENCY-1];

endmodule

// File: rtl/mem_resp_4c.sv
// Two-port (I/D) multi-cycle memory responder: D-priority arbiter with I-side starvation guard,
// word array, and a fixed-latency read response pipeline.
module mem_resp_4c
   import mem_pkg::*;
#(
   parameter int DWIDTH     = MEM_DWIDTH,
   parameter int AWIDTH     = MEM_AWIDTH,
   parameter int DEPTH_LOG2 = 15,
   parameter int LATENCY    = 4,
   parameter int STARVE     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req_valid,
   input  logic [AWIDTH-1:0] i_req_addr,
   output logic              i_req_ready,
   input  logic              d_req_valid,
   input  logic              d_req_wr,
   input  logic [AWIDTH-1:0] d_req_addr,
   input  logic [DWIDTH-1:0] d_req_wdata,
   output logic              d_req_ready,
   output logic              rsp_valid,
   output logic              rsp_port,
   output logic [DWIDTH-1:0] rsp_data,
   output logic              busy
);

   typedef struct packed {
      logic              valid;
      logic              port;
      logic [DWIDTH-1:0] data;
   } stage_t;

   localparam int              SW         = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
   localparam int              WORDS      = 1 << DEPTH_LOG2;
   localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE);

   logic [DWIDTH-1:0]     mem_q [WORDS];
   logic [SW-1:0]         starve_q, starve_d;
   logic                  grant_i, grant_d;
   logic [DEPTH_LOG2-1:0] i_idx, d_idx, rd_idx;
   stage_t                pipe_in, pipe_out;
   logic                  unused_addr;

   // Byte addresses: bit 0 selects nothing, bits above the array size wrap.
   assign i_idx       = i_req_addr[DEPTH_LOG2:1];
   assign d_idx       = d_req_addr[DEPTH_LOG2:1];
   assign unused_addr = ^{i_req_addr, d_req_addr};

   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (!rst) begin
         if (i_req_valid && (!d_req_valid || starve_q == STARVE_MAX)) begin
            grant_i = 1'b1;
         end else if (d_req_valid) begin
            grant_d = 1'b1;
         end
      end
   end

   assign i_req_ready = grant_i;
   assign d_req_ready = grant_d;

   always_comb begin
      starve_d = '0;
      if (i_req_valid && !grant_i) begin
         starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   // Array is deliberately outside reset so preloaded contents survive it.
   always_ff @(posedge clk) begin
      if (grant_d && d_req_wr) begin
         mem_q[d_idx] <= d_req_wdata;
      end
   end

   assign rd_idx = grant_i ? i_idx : d_idx;

   always_comb begin
      pipe_in.valid = grant_i | (grant_d & ~d_req_wr);
      pipe_in.port  = grant_d ? RSP_PORT_D : RSP_PORT_I;
      pipe_in.data  = mem_q[rd_idx];
   end

   resp_pipe #(
      .stage_t (stage_t),
      .LATENCY (LATENCY)
   ) u_resp_pipe (
      .clk       (clk),
      .rst       (rst),
      .stage_in  (pipe_in),
      .stage_out (pipe_out),
      .any_valid (busy)
   );

   assign rsp_valid = pipe_out.valid;
   assign rsp_port  = pipe_out.port;
   assign rsp_data  = pipe_out.data;

endmodule
